// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - key gesture classifier and LED mode sequencer
//
// Sorts debounced key strobes into short press, long press and double
// click, then steps a four-mode LED pattern engine (OFF/ON/BLINK/RUN).
//
// Ports:
//   sys_clk    - clock, rising edge
//   sys_rst    - synchronous active-high reset
//   key_flag   - one-cycle strobe, key_value valid with it
//   key_value  - debounced level, 0 = pressed, 1 = released
//   evt_short  - one-cycle pulse, short press
//   evt_long   - one-cycle pulse, long press
//   evt_double - one-cycle pulse, double click
//   mode       - 0 OFF, 1 ON, 2 BLINK, 3 RUN
//   led        - LED drive, active-high

module key_led_ctrl #(
   parameter int LED_W     = 4,
   parameter int LONG_CYC  = 50_000_000,
   parameter int DBL_CYC   = 15_000_000,
   parameter int BLINK_CYC = 12_500_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             key_flag,
   input  logic             key_value,
   output logic             evt_short,
   output logic             evt_long,
   output logic             evt_double,
   output logic [1:0]       mode,
   output logic [LED_W-1:0] led
);

   localparam int HW = (LONG_CYC  > 1) ? $clog2(LONG_CYC)  : 1;
   localparam int GW = (DBL_CYC   > 1) ? $clog2(DBL_CYC)   : 1;
   localparam int SW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(DBL_CYC - 1);
   localparam logic [SW-1:0] STEP_MAX = SW'(BLINK_CYC - 1);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_RUN   = 2'd3;

   typedef enum logic [1:0] {IDLE, PRESS1, WAIT2, WAIT_REL} state_t;

   state_t           state_q;
   logic             key_lvl_q;
   logic [HW-1:0]    hold_cnt_q;
   logic [GW-1:0]    gap_cnt_q;
   logic [SW-1:0]    step_cnt_q;
   logic             evt_short_q, evt_long_q, evt_double_q;
   logic [1:0]       mode_q, mode_d;
   logic [LED_W-1:0] led_q, led_load;
   logic             press, release_evt, mode_chg;

   // Only level changes count; a strobe repeating the tracked level is noise.
   always_comb begin
      press       = key_flag && !key_value &&  key_lvl_q;
      release_evt = key_flag &&  key_value && !key_lvl_q;
      mode_chg    = evt_short_q || evt_long_q || evt_double_q;

      mode_d = mode_q;
      if (evt_short_q)       mode_d = mode_q + 2'd1;
      else if (evt_double_q) mode_d = mode_q - 2'd1;
      else if (evt_long_q)   mode_d = MODE_OFF;

      led_load = '0;
      case (mode_d)
         MODE_ON, MODE_BLINK: led_load = '1;
         MODE_RUN:            led_load = LED_W'(1);
         default:             led_load = '0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         key_lvl_q    <= 1'b1;
         hold_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         step_cnt_q   <= '0;
         evt_short_q  <= 1'b0;
         evt_long_q   <= 1'b0;
         evt_double_q <= 1'b0;
         mode_q       <= MODE_OFF;
         led_q        <= '0;
      end else begin
         evt_short_q  <= 1'b0;
         evt_long_q   <= 1'b0;
         evt_double_q <= 1'b0;
         if (key_flag) key_lvl_q <= key_value;

         // Release/press are tested before the timeouts so they win ties.
         case (state_q)
            IDLE: begin
               if (press) begin
                  state_q    <= PRESS1;
                  hold_cnt_q <= '0;
               end
            end
            PRESS1: begin
               if (release_evt) begin
                  state_q   <= WAIT2;
                  gap_cnt_q <= '0;
               end else if (hold_cnt_q == HOLD_MAX) begin
                  evt_long_q <= 1'b1;
                  state_q    <= WAIT_REL;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            WAIT2: begin
               if (press) begin
                  evt_double_q <= 1'b1;
                  state_q      <= WAIT_REL;
               end else if (gap_cnt_q == GAP_MAX) begin
                  evt_short_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: begin
               if (release_evt) state_q <= IDLE;
            end
         endcase

         // Any event reloads, even when the mode value itself is unchanged.
         if (mode_chg) begin
            mode_q     <= mode_d;
            led_q      <= led_load;
            step_cnt_q <= '0;
         end else if (mode_q == MODE_BLINK || mode_q == MODE_RUN) begin
            if (step_cnt_q == STEP_MAX) begin
               step_cnt_q <= '0;
               if (mode_q == MODE_BLINK) led_q <= ~led_q;
               else                      led_q <= {led_q[LED_W-2:0], led_q[LED_W-1]};
            end else begin
               step_cnt_q <= step_cnt_q + 1'b1;
            end
         end
      end
   end

   assign evt_short  = evt_short_q;
   assign evt_long   = evt_long_q;
   assign evt_double = evt_double_q;
   assign mode       = mode_q;
   assign led        = led_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb/tb_key_led_ctrl.sv - directed self-checking bench for key_led_ctrl

module tb_key_led_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       key_flag = 1'b0;
   logic       key_value = 1'b1;
   logic       evt_short, evt_long, evt_double;
   logic [1:0] mode;
   logic [3:0] led;

   int checks = 0;
   int errors = 0;
   int n_short = 0, n_long = 0, n_double = 0, n_multi = 0;

   key_led_ctrl #(
      .LED_W(4), .LONG_CYC(20), .DBL_CYC(10), .BLINK_CYC(4)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .key_flag(key_flag), .key_value(key_value),
      .evt_short(evt_short), .evt_long(evt_long), .evt_double(evt_double),
      .mode(mode), .led(led)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (evt_short)  n_short++;
      if (evt_long)   n_long++;
      if (evt_double) n_double++;
      if (int'(evt_short) + int'(evt_long) + int'(evt_double) > 1) n_multi++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // One strobe; returns just after the edge that sampled it.
   task automatic strobe(input logic v);
      key_flag  = 1'b1;
      key_value = v;
      tick(1);
      key_flag  = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick(2);
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      int s0;
      do_reset();
      checks++;
      if ({evt_short, evt_long, evt_double, mode, led} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000000000", {evt_short, evt_long, evt_double, mode, led});
      end
      s0 = n_short + n_long + n_double;
      strobe(1'b1);
      tick(15);
      checks++;
      if (n_short + n_long + n_double !== s0) begin
         errors++;
         $display("FAIL ignore_same_level: events %0d expected %0d", n_short + n_long + n_double, s0);
      end
   endtask

   task automatic test_short();
      strobe(1'b0);
      tick(4);
      strobe(1'b1);
      tick(9);
      checks++;
      if (evt_short !== 1'b0) begin
         errors++;
         $display("FAIL short_early: evt_short %b expected 0", evt_short);
      end
      tick(1);
      checks++;
      if (evt_short !== 1'b1 || mode !== 2'd0) begin
         errors++;
         $display("FAIL short_pulse: evt_short %b mode %0d expected 1 / 0", evt_short, mode);
      end
      tick(1);
      checks++;
      if (evt_short !== 1'b0 || mode !== 2'd1 || led !== 4'b1111) begin
         errors++;
         $display("FAIL short_mode: evt %b mode %0d led %b expected 0 / 1 / 1111", evt_short, mode, led);
      end
   endtask

   task automatic test_long();
      int l0, o0;
      l0 = n_long;
      o0 = n_short + n_double;
      strobe(1'b0);
      tick(19);
      checks++;
      if (evt_long !== 1'b0) begin
         errors++;
         $display("FAIL long_early: evt_long %b expected 0", evt_long);
      end
      tick(1);
      checks++;
      if (evt_long !== 1'b1) begin
         errors++;
         $display("FAIL long_pulse: evt_long %b expected 1", evt_long);
      end
      tick(4);
      strobe(1'b1);
      tick(15);
      checks++;
      if (mode !== 2'd0 || led !== 4'b0000 || n_long - l0 !== 1 || n_short + n_double !== o0) begin
         errors++;
         $display("FAIL long_result: mode %0d led %b longs %0d others %0d expected 0 / 0000 / 1 / %0d",
                  mode, led, n_long - l0, n_short + n_double, o0);
      end
   endtask

   task automatic test_double_run();
      logic [3:0] exp_led [5];
      exp_led[0] = 4'b0001; exp_led[1] = 4'b0010; exp_led[2] = 4'b0100;
      exp_led[3] = 4'b1000; exp_led[4] = 4'b0001;
      strobe(1'b0);
      tick(2);
      strobe(1'b1);
      tick(2);
      strobe(1'b0);
      checks++;
      if (evt_double !== 1'b1) begin
         errors++;
         $display("FAIL double_pulse: evt_double %b expected 1", evt_double);
      end
      tick(1);
      checks++;
      if (mode !== 2'd3) begin
         errors++;
         $display("FAIL double_mode: mode %0d expected 3", mode);
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick(4);
         checks++;
         if (led !== exp_led[i]) begin
            errors++;
            $display("FAIL run_step%0d: led %b expected %b", i, led, exp_led[i]);
         end
      end
      strobe(1'b1);
   endtask

   task automatic test_boundary_release();
      int l0;
      l0 = n_long;
      strobe(1'b0);
      tick(19);
      strobe(1'b1);
      tick(9);
      checks++;
      if (evt_short !== 1'b0) begin
         errors++;
         $display("FAIL bnd_rel_early: evt_short %b expected 0", evt_short);
      end
      tick(1);
      checks++;
      if (evt_short !== 1'b1) begin
         errors++;
         $display("FAIL bnd_rel_short: evt_short %b expected 1", evt_short);
      end
      tick(1);
      checks++;
      if (mode !== 2'd0 || led !== 4'b0000 || n_long !== l0) begin
         errors++;
         $display("FAIL bnd_rel_result: mode %0d led %b longs %0d expected 0 / 0000 / %0d", mode, led, n_long, l0);
      end
   endtask

   task automatic test_boundary_gap();
      int s0;
      s0 = n_short;
      strobe(1'b0);
      tick(1);
      strobe(1'b1);
      tick(9);
      strobe(1'b0);
      checks++;
      if (evt_double !== 1'b1 || evt_short !== 1'b0) begin
         errors++;
         $display("FAIL bnd_gap_double: double %b short %b expected 1 / 0", evt_double, evt_short);
      end
      tick(1);
      checks++;
      if (mode !== 2'd3 || led !== 4'b0001) begin
         errors++;
         $display("FAIL bnd_gap_mode: mode %0d led %b expected 3 / 0001", mode, led);
      end
      strobe(1'b1);
      tick(12);
      checks++;
      if (n_short !== s0) begin
         errors++;
         $display("FAIL bnd_gap_noshort: shorts %0d expected %0d", n_short, s0);
      end
   endtask

   task automatic do_short();
      strobe(1'b0);
      tick(2);
      strobe(1'b1);
      tick(11);
   endtask

   task automatic test_blink_wrap();
      logic [1:0] exp_mode [4];
      exp_mode[0] = 2'd1; exp_mode[1] = 2'd2; exp_mode[2] = 2'd3; exp_mode[3] = 2'd0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_short();
         checks++;
         if (mode !== exp_mode[i]) begin
            errors++;
            $display("FAIL wrap_mode%0d: mode %0d expected %0d", i, mode, exp_mode[i]);
         end
         if (i == 1) begin
            checks++;
            if (led !== 4'b1111) begin
               errors++;
               $display("FAIL blink_load: led %b expected 1111", led);
            end
            tick(3);
            checks++;
            if (led !== 4'b1111) begin
               errors++;
               $display("FAIL blink_hold: led %b expected 1111", led);
            end
            tick(1);
            checks++;
            if (led !== 4'b0000) begin
               errors++;
               $display("FAIL blink_off: led %b expected 0000", led);
            end
            tick(4);
            checks++;
            if (led !== 4'b1111) begin
               errors++;
               $display("FAIL blink_on: led %b expected 1111", led);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      do_reset();
      do_short();
      do_short();
      checks++;
      if (mode !== 2'd2) begin
         errors++;
         $display("FAIL mid_setup: mode %0d expected 2", mode);
      end
      strobe(1'b0);
      tick(1);
      strobe(1'b1);
      tick(3);
      s0 = n_short;
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
      checks++;
      if ({evt_short, evt_long, evt_double, mode, led} !== 9'b0) begin
         errors++;
         $display("FAIL mid_reset_out: got %b expected 000000000", {evt_short, evt_long, evt_double, mode, led});
      end
      tick(15);
      checks++;
      if (n_short !== s0 || mode !== 2'd0) begin
         errors++;
         $display("FAIL mid_no_event: shorts %0d mode %0d expected %0d / 0", n_short, mode, s0);
      end
      do_short();
      checks++;
      if (mode !== 2'd1) begin
         errors++;
         $display("FAIL mid_idle_after: mode %0d expected 1", mode);
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_double_run();
      test_boundary_release();
      test_boundary_gap();
      test_blink_wrap();
      test_reset_mid();
      checks++;
      if (n_multi !== 0) begin
         errors++;
         $display("FAIL one_event: overlapping cycles %0d expected 0", n_multi);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
